// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_pkg
//  Description : Shared definitions for the note recorder and the auto-play
//                song player: note code width, rest code, beat/depth defaults
//                and the recorder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_pkg;

    localparam int NOTE_W              = 5;
    localparam logic [NOTE_W-1:0] REST = '0;

    // Defaults shared with the auto-play player so recordings play back at
    // the same tempo and fit the same note memory.
    localparam int DEFAULT_BEAT_CYCLES = 6250002;
    localparam int DEFAULT_DEPTH       = 128;
    localparam int DEFAULT_AW          = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REC    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/note_ram.sv
`default_nettype none
// ============================================================================
//  Module      : note_ram
//  Description : Simple dual-port note memory, DEPTH x NOTE_W. One write port,
//                one registered read port (1-cycle latency). A read of the
//                address being written in the same cycle returns old data.
//                Contents are not reset; only the read register is.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_we/i_waddr/i_wdata - write port
//                i_raddr/o_rdata - read port (o_rdata registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module note_ram
    import note_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [NOTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [NOTE_W-1:0] o_rdata
);

    logic [NOTE_W-1:0] r_mem [DEPTH];
    logic [NOTE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : note_recorder
//  Description : Records a live note stream into note memory, one entry per
//                beat, for later playback through the read port.
//                Optional macro NOTE_REC_TRIM_EN: on entering DONE, rec_len is
//                cut back to the last non-rest entry (trailing rests dropped).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rec_start, rec_stop - single-cycle control pulses
//                pause               - level, freezes beat timing and writes
//                note_in             - live note code (0 = rest)
//                rd_addr / rd_note   - playback read port, 1-cycle latency
//                rec_len             - valid entries (0..DEPTH)
//                recording/get_pause/done - state indicators
//  Revision    : 1.0 - initial release
// ============================================================================
module note_recorder
    import note_pkg::*;
#(
    parameter int BEAT_CYCLES = DEFAULT_BEAT_CYCLES,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int AW          = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic              pause,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [AW-1:0]     rd_addr,
    output logic [NOTE_W-1:0] rd_note,
    output logic [AW:0]       rec_len,
    output logic              recording,
    output logic              get_pause,
    output logic              done
);

    localparam int              c_BW          = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [c_BW-1:0] c_BEAT_LAST   = c_BW'(BEAT_CYCLES - 1);
    localparam logic [AW:0]     c_LEN_FULL_M1 = (AW+1)'(DEPTH - 1);

    rec_state_t      r_state;
    rec_state_t      w_state_nxt;
    logic [c_BW-1:0] r_beat_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_rec_len;
    logic            w_active;
    logic            w_tick;
    logic            w_full;
    logic            w_start;
    logic            w_enter_done;

    // Beat timing runs whenever a session is open and pause is low, so a
    // released pause resumes counting in the same cycle it drops.
    assign w_active = ((r_state == REC) || (r_state == PAUSED)) && !pause;
    assign w_tick   = w_active && (r_beat_cnt == c_BEAT_LAST);
    assign w_full   = w_tick && (r_rec_len == c_LEN_FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_enter_done = 1'b0;
        recording    = 1'b0;
        get_pause    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                // rec_stop is meaningless here, so rec_start always wins.
                if (rec_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = REC;
                end
            end
            REC, PAUSED: begin
                recording = (r_state == REC);
                get_pause = (r_state == PAUSED);
                if (rec_stop || w_full) begin
                    w_enter_done = 1'b1;
                    w_state_nxt  = DONE;
                end else if (pause) begin
                    w_state_nxt = PAUSED;
                end else begin
                    w_state_nxt = REC;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef NOTE_REC_TRIM_EN
    logic [AW:0] r_last_nz;
    logic [AW:0] w_last_nz_nxt;

    // Include the current write so a stop/full on a tick sees its own note.
    assign w_last_nz_nxt = (w_tick && (note_in != REST)) ? ({1'b0, r_wr_ptr} + 1'b1) : r_last_nz;
`endif

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_beat_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rec_len  <= '0;
`ifdef NOTE_REC_TRIM_EN
            r_last_nz  <= '0;
`endif
        end else begin
            if (w_active) begin
                r_beat_cnt <= w_tick ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_tick) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_rec_len <= r_rec_len + 1'b1;
            end
`ifdef NOTE_REC_TRIM_EN
            r_last_nz <= w_last_nz_nxt;
            if (w_enter_done) begin
                r_rec_len <= w_last_nz_nxt;
            end
`endif
        end
    end

    assign rec_len = r_rec_len;

    note_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_note_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_tick),
        .i_waddr (r_wr_ptr),
        .i_wdata (note_in),
        .i_raddr (rd_addr),
        .o_rdata (rd_note)
    );

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_recorder
//  Description : Self-checking bench for note_recorder (BEAT_CYCLES=4,
//                DEPTH=8). A queue-based model of the recording rules is
//                compared against the DUT on every falling edge; directed
//                tests add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_recorder;

    localparam int BEAT  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef NOTE_REC_TRIM_EN
    localparam int TRIM_LEN = 2;
`else
    localparam int TRIM_LEN = 4;
`endif

    logic          clk;
    logic          rst;
    logic          rec_start;
    logic          rec_stop;
    logic          pause;
    logic [4:0]    note_in;
    logic [AW-1:0] rd_addr;
    logic [4:0]    rd_note;
    logic [AW:0]   rec_len;
    logic          recording;
    logic          get_pause;
    logic          done;

    note_recorder #(
        .BEAT_CYCLES (BEAT),
        .DEPTH       (DEPTH),
        .AW          (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rec_start (rec_start),
        .rec_stop  (rec_stop),
        .pause     (pause),
        .note_in   (note_in),
        .rd_addr   (rd_addr),
        .rd_note   (rd_note),
        .rec_len   (rec_len),
        .recording (recording),
        .get_pause (get_pause),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_REC = 1, M_PAUSED = 2, M_DONE = 3;
    int         m_mode = M_IDLE;
    int         m_run  = 0;          // unpaused cycles since session start
    logic [4:0] m_q[$];              // notes recorded this session
    logic [4:0] m_mem [DEPTH];
    bit         m_ok  [DEPTH];
    int         exp_len = 0;
    logic [4:0] exp_rd = '0;
    bit         exp_rd_ok = 1'b0;
    bit         m_live = 1'b0;

    function automatic int kept_len();
        int n;
        n = m_q.size();
`ifdef NOTE_REC_TRIM_EN
        while (n > 0 && m_q[n-1] == 5'd0) n--;
`endif
        return n;
    endfunction

    always @(posedge clk) begin
        exp_rd    = m_mem[rd_addr];
        exp_rd_ok = m_ok[rd_addr];
        if (rst) begin
            m_mode = M_IDLE; m_run = 0; m_q.delete(); exp_len = 0;
            exp_rd = '0; exp_rd_ok = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (rec_start) begin
                    m_mode = M_REC; m_run = 0; m_q.delete(); exp_len = 0;
                end
                default: begin
                    if (!pause) begin
                        m_run++;
                        if (m_run % BEAT == 0) begin
                            m_mem[m_q.size()] = note_in;
                            m_ok[m_q.size()]  = 1'b1;
                            m_q.push_back(note_in);
                        end
                    end
                    if (rec_stop || m_q.size() == DEPTH) begin
                        m_mode = M_DONE; exp_len = kept_len();
                    end else begin
                        m_mode  = pause ? M_PAUSED : M_REC;
                        exp_len = m_q.size();
                    end
                end
            endcase
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_recording", recording, m_mode == M_REC);
            chk("m_get_pause", get_pause, m_mode == M_PAUSED);
            chk("m_done",      done,      m_mode == M_DONE);
            chk("m_rec_len",   rec_len,   exp_len);
            if (exp_rd_ok) chk("m_rd_note", rd_note, exp_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        rec_start = 1'b1; step(1); rec_start = 1'b0;
    endtask

    task automatic pulse_stop();
        rec_stop = 1'b1; step(1); rec_stop = 1'b0;
    endtask

    task automatic read_chk(input string name, input int addr, input int exp);
        rd_addr = AW'(addr); step(1);
        chk(name, rd_note, exp);
    endtask

    int seq [8] = '{8, 9, 10, 11, 12, 11, 10, 9};

    initial begin
        rst = 1'b1; rec_start = 1'b0; rec_stop = 1'b0; pause = 1'b0;
        note_in = '0; rd_addr = '0;
        step(2);
        chk("rst_rec_len",   rec_len,   0);
        chk("rst_recording", recording, 0);
        chk("rst_get_pause", get_pause, 0);
        chk("rst_done",      done,      0);
        chk("rst_rd_note",   rd_note,   0);
        rst = 1'b0;

        // Test 1: steady note, three beats, then stop
        pulse_start(); note_in = 5'd10;
        chk("t1_recording", recording, 1);
        step(3); chk("t1_len_before_tick", rec_len, 0);
        step(1); chk("t1_first_write",     rec_len, 1);
        step(8); chk("t1_len3",            rec_len, 3);
        pulse_stop();
        chk("t1_done", done, 1);
        chk("t1_len",  rec_len, 3);
        for (int a = 0; a < 3; a++) read_chk("t1_mem", a, 10);

        // Test 2: pause at beat_cnt=2 for 5 cycles, note changes while paused
        pulse_start(); note_in = 5'd10;
        step(2); pause = 1'b1;
        step(1); chk("t2_get_pause", get_pause, 1); chk("t2_not_rec", recording, 0);
        step(1); note_in = 5'd12;
        step(3); chk("t2_no_write", rec_len, 0);
        pause = 1'b0;
        step(1); chk("t2_unpaused", get_pause, 0); chk("t2_len_still0", rec_len, 0);
        step(1); chk("t2_write", rec_len, 1);
        pulse_stop();
        read_chk("t2_mem0", 0, 12);

        // Test 3: fill all 8 entries
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            note_in = 5'(seq[k]);
            step(4);
            chk("t3_done_on_full", done, (k == 7));
        end
        chk("t3_len_full", rec_len, 8);
        pulse_stop();
        chk("t3_stop_ignored", done, 1); chk("t3_len_kept", rec_len, 8);
        for (int a = 0; a < 8; a++) read_chk("t3_mem", a, seq[a]);

        // Test 4: stop on the second tick keeps that write
        pulse_start(); note_in = 5'd3;
        step(4); note_in = 5'd5;
        step(3); pulse_stop();
        chk("t4_len", rec_len, 2); chk("t4_done", done, 1);
        read_chk("t4_mem1", 1, 5);

        // Test 5: reset mid-recording, then restart
        pulse_start(); note_in = 5'd7;
        step(13); chk("t5_len3", rec_len, 3);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("t5_rst_len", rec_len, 0); chk("t5_rst_rec", recording, 0);
        chk("t5_rst_done", done, 0);
        pulse_start(); step(4);
        chk("t5_restart_len", rec_len, 1); chk("t5_restart_rec", recording, 1);
        pulse_stop();

        // Test 6: start+stop together from DONE, then trailing rests
        rec_start = 1'b1; rec_stop = 1'b1; step(1); rec_start = 1'b0; rec_stop = 1'b0;
        chk("t6_start_wins", recording, 1);
        note_in = 5'd10; step(4);
        note_in = 5'd11; step(4);
        note_in = 5'd0;  step(8);
        chk("t6_len_pre_stop", rec_len, 4);
        pulse_stop();
        chk("t6_trim_len", rec_len, TRIM_LEN);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
